// File: rtl/adc_pack_pkg.sv
// Shared field layout for the ADC pack/unpack datapaths.
// Word layout, MSB first: dch1 | pad1 | dch2 | pad2.
package adc_pack_pkg;

   localparam int CH_W   = 6;
   localparam int PAD_W  = 2;
   localparam int WORD_W = 2 * (CH_W + PAD_W);

   localparam int DCH1_MSB = WORD_W - 1;
   localparam int DCH1_LSB = DCH1_MSB - CH_W + 1;
   localparam int PAD1_MSB = DCH1_LSB - 1;
   localparam int PAD1_LSB = PAD1_MSB - PAD_W + 1;
   localparam int DCH2_MSB = PAD1_LSB - 1;
   localparam int DCH2_LSB = DCH2_MSB - CH_W + 1;
   localparam int PAD2_MSB = DCH2_LSB - 1;
   localparam int PAD2_LSB = 0;

   typedef struct packed {
      logic [CH_W-1:0] dch1;
      logic [CH_W-1:0] dch2;
   } sample_pair_t;

endpackage

// File: rtl/dco_skid2.sv
// Two-entry skid buffer: a head (output) register plus one skid entry.
// The writer must not push when occupancy is 2 unless it pops in the same cycle;
// occupancy is exported so the writer can run a credit scheme on it.
module dco_skid2 #(
   parameter int W = 12
) (
   input  logic         dco,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic [1:0]   occupancy
);

   logic [W-1:0] head_r;
   logic [W-1:0] tail_r;
   logic [1:0]   occ_r;
   logic [W-1:0] head_n_s;
   logic [W-1:0] tail_n_s;
   logic [1:0]   occ_n_s;
   logic         pop_s;

   assign pop_s = (occ_r != 2'd0) && out_ready;

   // Next-state: strict FIFO order, the skid entry refills the head on pop
   always_comb begin
      head_n_s = head_r;
      tail_n_s = tail_r;
      occ_n_s  = occ_r;
      case ({in_valid, pop_s})
         2'b01: begin
            if (occ_r == 2'd2) begin
               head_n_s = tail_r;
               occ_n_s  = 2'd1;
            end else begin
               occ_n_s  = 2'd0;
            end
         end
         2'b10: begin
            if (occ_r == 2'd0) begin
               head_n_s = in_data;
               occ_n_s  = 2'd1;
            end else begin
               tail_n_s = in_data;
               occ_n_s  = 2'd2;
            end
         end
         2'b11: begin
            if (occ_r == 2'd2) begin
               head_n_s = tail_r;
               tail_n_s = in_data;
               occ_n_s  = 2'd2;
            end else begin
               head_n_s = in_data;
               occ_n_s  = 2'd1;
            end
         end
         default: begin
            occ_n_s = occ_r;
         end
      endcase
   end

   // Storage registers
   always_ff @(posedge dco or negedge rst_n) begin
      if (!rst_n) begin
         head_r <= {W{1'b0}};
         tail_r <= {W{1'b0}};
         occ_r  <= 2'd0;
      end else begin
         head_r <= head_n_s;
         tail_r <= tail_n_s;
         occ_r  <= occ_n_s;
      end
   end

   assign out_valid = (occ_r != 2'd0);
   assign out_data  = head_r;
   assign occupancy = occ_r;

endmodule

// File: rtl/adc_unpack_stream.sv
// Unpacks 16-bit words from a standard (non-FWFT) host-to-FPGA FIFO into
// dch1/dch2 sample pairs on a valid/ready stream, one word per clock.
// Optional build macro PAD_CHECK_EN: flags and counts words with nonzero pad bits.
module adc_unpack_stream #(
   parameter int CH_W  = adc_pack_pkg::CH_W,
   parameter int PAD_W = adc_pack_pkg::PAD_W,
   parameter int CNT_W = 16
) (
   input  logic                      dco,
   input  logic                      rst_n,
   input  logic [2*(CH_W+PAD_W)-1:0] fifo_dout,
   input  logic                      fifo_empty,
   output logic                      fifo_rd_en,
   output logic [CH_W-1:0]           dch1,
   output logic [CH_W-1:0]           dch2,
   output logic                      out_valid,
   input  logic                      out_ready,
   input  logic                      cnt_clr,
   output logic [CNT_W-1:0]          underrun_cnt,
   output logic                      pad_err,
   output logic [CNT_W-1:0]          pad_err_cnt
);

   localparam int WORD_W = 2 * (CH_W + PAD_W);
   localparam int PAIR_W = 2 * CH_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              inflight_r;
   logic              rd_arm_r;
   logic              started_r;
   logic [CNT_W-1:0]  underrun_r;
   logic [1:0]        occ_s;
   logic              pop_s;
   logic              rd_en_s;
   logic [2:0]        credit_s;
   logic [2:0]        limit_s;
   logic [PAIR_W-1:0] cap_pair_s;
   logic [PAIR_W-1:0] out_pair_s;

   assign cap_pair_s = {fifo_dout[WORD_W-1 -: CH_W], fifo_dout[CH_W+PAD_W-1 -: CH_W]};

   dco_skid2 #(
      .W (PAIR_W)
   ) u_skid (
      .dco       (dco),
      .rst_n     (rst_n),
      .in_valid  (inflight_r),
      .in_data   (cap_pair_s),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_pair_s),
      .occupancy (occ_s)
   );

   assign dch1  = out_pair_s[PAIR_W-1 -: CH_W];
   assign dch2  = out_pair_s[CH_W-1:0];
   assign pop_s = out_valid && out_ready;

   // Read credit: stored + in-flight words after this cycle's pop must stay below 2
   always_comb begin
      credit_s = {1'b0, occ_s} + {2'b00, inflight_r};
      limit_s  = 3'd2 + {2'b00, pop_s};
      if (rd_arm_r && !fifo_empty && (credit_s < limit_s)) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
   end

   assign fifo_rd_en = rd_en_s;

   // Read pipeline tracking; rd_arm_r keeps the strobe low while reset is held
   always_ff @(posedge dco or negedge rst_n) begin
      if (!rst_n) begin
         inflight_r <= 1'b0;
         rd_arm_r   <= 1'b0;
         started_r  <= 1'b0;
      end else begin
         inflight_r <= rd_en_s;
         rd_arm_r   <= 1'b1;
         started_r  <= started_r | pop_s;
      end
   end

   // Saturating underrun counter: consumer ready but nothing to give after the stream started
   always_ff @(posedge dco or negedge rst_n) begin
      if (!rst_n) begin
         underrun_r <= {CNT_W{1'b0}};
      end else if (cnt_clr) begin
         underrun_r <= {CNT_W{1'b0}};
      end else if (started_r && out_ready && !out_valid && (underrun_r != CNT_MAX)) begin
         underrun_r <= underrun_r + CNT_ONE;
      end
   end

   assign underrun_cnt = underrun_r;

`ifdef PAD_CHECK_EN
   logic             pad_err_r;
   logic [CNT_W-1:0] pad_cnt_r;
   logic             pad_hit_s;

   function automatic logic pad_nonzero(input logic [WORD_W-1:0] word);
      return (|word[CH_W+2*PAD_W-1 -: PAD_W]) | (|word[PAD_W-1:0]);
   endfunction

   assign pad_hit_s = inflight_r && pad_nonzero(fifo_dout);

   // Sticky pad-error flag and saturating pad-error count, checked on each captured word
   always_ff @(posedge dco or negedge rst_n) begin
      if (!rst_n) begin
         pad_err_r <= 1'b0;
         pad_cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_clr) begin
         pad_err_r <= 1'b0;
         pad_cnt_r <= {CNT_W{1'b0}};
      end else if (pad_hit_s) begin
         pad_err_r <= 1'b1;
         if (pad_cnt_r != CNT_MAX) begin
            pad_cnt_r <= pad_cnt_r + CNT_ONE;
         end
      end
   end

   assign pad_err     = pad_err_r;
   assign pad_err_cnt = pad_cnt_r;
`else
   logic pad_unused_s;
   assign pad_unused_s = ^{fifo_dout[CH_W+2*PAD_W-1 -: PAD_W], fifo_dout[PAD_W-1:0]};
   assign pad_err      = 1'b0;
   assign pad_err_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_adc_unpack_stream.sv
// Directed bench for adc_unpack_stream: FIFO model, in-order scoreboard,
// stall-stability and read-credit checks, plus a CNT_W=4 copy for saturation.
module tb_adc_unpack_stream;

`ifdef PAD_CHECK_EN
   localparam bit PAD_ON = 1'b1;
`else
   localparam bit PAD_ON = 1'b0;
`endif

   logic        dco = 1'b0;
   logic        rst_n;
   logic [15:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [5:0]  dch1, dch2;
   logic        out_valid;
   logic        out_ready;
   logic        cnt_clr;
   logic [15:0] underrun_cnt;
   logic        pad_err;
   logic [15:0] pad_err_cnt;

   logic        unused_rd4;
   logic [5:0]  unused_d1_4, unused_d2_4;
   logic        v4;
   logic [3:0]  ur4;
   logic        unused_pe4;
   logic [3:0]  unused_pec4;

   always #5 dco = ~dco;

   adc_unpack_stream u_dut (
      .dco(dco), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .dch1(dch1), .dch2(dch2), .out_valid(out_valid),
      .out_ready(out_ready), .cnt_clr(cnt_clr), .underrun_cnt(underrun_cnt),
      .pad_err(pad_err), .pad_err_cnt(pad_err_cnt)
   );

   adc_unpack_stream #(.CNT_W(4)) u_dut4 (
      .dco(dco), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_en(unused_rd4), .dch1(unused_d1_4), .dch2(unused_d2_4), .out_valid(v4),
      .out_ready(out_ready), .cnt_clr(cnt_clr), .underrun_cnt(ur4),
      .pad_err(unused_pe4), .pad_err_cnt(unused_pec4)
   );

   typedef struct {
      logic [15:0] word;
      logic [5:0]  e1;
      logic [5:0]  e2;
      logic        bad;
   } vec_t;

   vec_t        vecs[6];
   logic [15:0] fifo_q[$];
   logic [11:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          outstanding = 0;
   int          pops = 0;
   int          cur_run = 0;
   int          max_run = 0;
   bit          hold_pending = 1'b0;
   logic [12:0] held;
   logic        last_rd, last_empty, last_valid;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: condition violated", name);
   endtask

   task automatic push(input logic [15:0] w, input logic [11:0] e);
      fifo_q.push_back(w);
      exp_q.push_back(e);
      fifo_empty = 1'b0;
   endtask

   // One clock: sample just before the edge, then model the FIFO just after it
   task automatic tick();
      logic rd_now, pop_now;
      #4;
      rd_now     = fifo_rd_en;
      pop_now    = out_valid && out_ready;
      last_rd    = rd_now;
      last_empty = fifo_empty;
      last_valid = out_valid;
      if (rst_n) begin
         if (hold_pending) check("stall_hold", {19'd0, out_valid, dch1, dch2}, {19'd0, held});
         hold_pending = out_valid && !out_ready;
         held = {out_valid, dch1, dch2};
         if (rd_now) begin
            n_cmp++;
            if (outstanding + 1 - int'(pop_now) > 2) begin
               n_bad++;
               $display("FAIL rd_credit: outstanding %0d pop %0d, limit 2", outstanding, pop_now);
            end
         end
         if (pop_now) begin
            if (exp_q.size() == 0) fail_now("spurious_pop");
            else check("pop_data", {20'd0, dch1, dch2}, {20'd0, exp_q.pop_front()});
            pops++;
         end
         if (out_valid) begin
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
         end else begin
            cur_run = 0;
         end
      end
      @(posedge dco);
      #1;
      if (rst_n) begin
         if (rd_now && fifo_q.size() > 0) begin
            fifo_dout = fifo_q.pop_front();
            outstanding++;
         end
         if (pop_now) outstanding--;
      end
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic run_pops(input int target, input int budget);
      int n;
      n = 0;
      while (pops < target && n < budget) begin
         tick();
         n++;
      end
      if (pops < target) fail_now("pop_timeout");
   endtask

   initial begin
      int n, lat, pre, gaps;
      logic [5:0] a, b;

      vecs[0] = '{16'hA854, 6'h2A, 6'h15, 1'b0};
      vecs[1] = '{16'hA955, 6'h2A, 6'h15, 1'b1};
      vecs[2] = '{16'hFC00, 6'h3F, 6'h00, 1'b0};
      vecs[3] = '{16'h00FC, 6'h00, 6'h3F, 1'b0};
      vecs[4] = '{16'hFFFF, 6'h3F, 6'h3F, 1'b1};
      vecs[5] = '{16'h0001, 6'h00, 6'h00, 1'b1};

      rst_n = 1'b0; fifo_dout = 16'h0000; fifo_empty = 1'b1;
      out_ready = 1'b0; cnt_clr = 1'b0;
      #3;
      check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_dch1", {26'd0, dch1}, 32'd0);
      check("rst_dch2", {26'd0, dch2}, 32'd0);
      check("rst_underrun", {16'd0, underrun_cnt}, 32'd0);
      check("rst_pad_err", {31'd0, pad_err}, 32'd0);
      check("rst_pad_cnt", {16'd0, pad_err_cnt}, 32'd0);
      @(posedge dco); #1;
      rst_n = 1'b1;
      tick(); tick();

      // Table: single words, latency, unpack, pad check, underrun after the pulse
      for (int k = 0; k < 6; k++) begin
         out_ready = 1'b0; cnt_clr = 1'b1;
         tick();
         cnt_clr = 1'b0;
         push(vecs[k].word, {vecs[k].e1, vecs[k].e2});
         out_ready = 1'b1;
         n = 0;
         do begin tick(); n++; end while (!last_rd && n < 5);
         if (!last_rd) fail_now("first_rd_timeout");
         lat = 0;
         do begin tick(); lat++; end while (!last_valid && lat < 6);
         check("latency", lat, 32'd2);
         check("pad_err", {31'd0, pad_err}, {31'd0, PAD_ON & vecs[k].bad});
         check("pad_err_cnt", {16'd0, pad_err_cnt}, {31'd0, PAD_ON & vecs[k].bad});
         pre = (k == 0) ? 0 : 2;
         tick();
         check("single_pulse", {31'd0, last_valid}, 32'd0);
         check("underrun_1", {16'd0, underrun_cnt}, pre + 1);
         tick(); tick(); tick();
         check("underrun_4", {16'd0, underrun_cnt}, pre + 4);
      end

      // Pad flags clear on cnt_clr
      out_ready = 1'b0; cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("pad_err_clr", {31'd0, pad_err}, 32'd0);
      check("pad_cnt_clr", {16'd0, pad_err_cnt}, 32'd0);

      // Burst of 100 at full rate
      for (int i = 0; i < 100; i++) begin
         a = 6'(i); b = 6'd63 - 6'(i);
         push({a, 2'b00, b, 2'b00}, {a, b});
      end
      pops = 0; max_run = 0; cur_run = 0; gaps = 0;
      tick(); tick();
      out_ready = 1'b1;
      n = 0;
      while (pops < 100 && n < 300) begin
         tick();
         n++;
         if (!last_empty && !last_rd) gaps++;
      end
      if (pops < 100) fail_now("burst_timeout");
      check("burst_rd_gaps", gaps, 32'd0);
      check("burst_run", max_run, 32'd100);
      check("burst_underrun", {16'd0, underrun_cnt}, 32'd0);
      check("burst_left", exp_q.size(), 32'd0);
      out_ready = 1'b0;

      // Backpressure burst, ready pattern 1,0,0,...
      for (int i = 0; i < 100; i++) begin
         a = 6'(i * 5); b = 6'(i ^ 42);
         push({a, 2'b00, b, 2'b00}, {a, b});
      end
      pops = 0;
      n = 0;
      while (pops < 100 && n < 1000) begin
         out_ready = ((n % 3) == 0);
         tick();
         n++;
      end
      check("bp_pops", pops, 32'd100);
      check("bp_left", exp_q.size(), 32'd0);

      // Saturation: starve 20 cycles after a clear
      out_ready = 1'b1; cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      repeat (20) tick();
      check("sat_cnt4", {28'd0, ur4}, 32'h0000000F);
      check("sat_cnt16", {16'd0, underrun_cnt}, 32'd20);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr_wins_cnt4", {28'd0, ur4}, 32'd0);
      check("clr_wins_cnt16", {16'd0, underrun_cnt}, 32'd0);

      // Reset mid-stream with one word buffered and one in flight
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         a = 6'h30 + 6'(i); b = 6'h0F + 6'(i);
         push({a, 2'b00, b, 2'b00}, {a, b});
      end
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_dch1", {26'd0, dch1}, 32'd0);
      check("mid_rst_dch2", {26'd0, dch2}, 32'd0);
      check("mid_rst_valid4", {31'd0, v4}, 32'd0);
      repeat (outstanding) void'(exp_q.pop_front());
      outstanding = 0;
      hold_pending = 1'b0;
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      pops = 0;
      run_pops(4, 50);
      check("post_rst_pops", pops, 32'd4);
      check("post_rst_left", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
